test_ram_bus_master: RTL and testbench
======================================

Name: test_ram_bus_master

Overview:
- Upstream requester for the block-RAM test memory. It turns a CPU-side byte or 16-bit word access into one or two byte transactions on the RAM's request/ready handshake.
- It holds address, write enable and write data stable until ready, captures read bytes, and returns one acknowledge per CPU request.
- It sits between the 65c816 core's bus logic and the test RAM.

Parameters:
- ADDR_WIDTH, 16, width of CPU and memory byte address; word high byte wraps modulo 2^ADDR_WIDTH.
- TIMEOUT_CYCLES, 15, max cycles mem_req may stay high without mem_ready (used only with the optional feature); must be >= 3.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cpu_req  in  1  access request; held high until cpu_ack; sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req
- cpu_wide  in  1  1 = 16-bit little-endian word, 0 = byte; sampled with cpu_req
- cpu_addr  in  ADDR_WIDTH  byte address (low byte for word access)
- cpu_wdata  in  16  write data; [7:0] used for byte access
- cpu_rdata  out  16  read data; byte reads zero-extend
- cpu_ack  out  1  one-cycle completion pulse
- cpu_busy  out  1  high from acceptance through the cpu_ack cycle
- mem_req  out  1  RAM request (RAM req_rdwr)
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data
- mem_ready  in  1  RAM data_ready
- error  out  1  timeout flag (constant 0 without optional feature)

Behaviour:
- Reset (async, rst_n low): state IDLE. cpu_ack, cpu_busy, mem_req, mem_we and error are 0. cpu_rdata, mem_addr and mem_wdata are 0. Releasing reset mid-transaction abandons it; no ack is issued.
- All outputs are registered.
- States:
  - IDLE:
    - cpu_req=1: latch we, wide, addr and wdata into internal registers.
    - Drive mem_addr=addr, mem_wdata=wdata[7:0], mem_we=we, mem_req=1. Set busy=1 and go to LO.
  - LO:
    - Hold mem_* stable; ignore mem_ready while mem_req=0.
    - On mem_ready=1: capture mem_rdata into rdata[7:0] if read, then drop mem_req and mem_we.
    - Go to GAP if wide, else ACK.
  - GAP: exactly one idle cycle with mem_req=0. Then drive mem_addr=addr+1 (wrap to 0 at all-ones), mem_wdata=wdata[15:8], mem_we=we, mem_req=1, and go to HI.
  - HI: same as LO. Capture into rdata[15:8], then go to ACK.
  - ACK:
    - cpu_ack=1 for this cycle only. cpu_rdata is updated (upper byte 0 for a byte read) and held until the next ACK.
    - busy deasserts next cycle; return to IDLE.
    - A still-high cpu_req in IDLE on the following cycle starts a new access, so the CPU must drop cpu_req after ack.
- mem_req is never high in two consecutive transactions without at least one low cycle.
- Writes leave cpu_rdata unchanged.
- Latency: cpu_ack is asserted on the cycle after the edge where mem_ready is sampled high for the final byte.
- mem_ready high in IDLE, GAP or ACK is ignored.
- cpu_addr, cpu_we and cpu_wdata changes after acceptance have no effect.

Optional Feature:
- Macro: TRB_TIMEOUT_EN.
- Defined:
  - A counter clears whenever mem_req rises and counts each cycle in LO/HI without mem_ready.
  - On reaching TIMEOUT_CYCLES: drop mem_req/mem_we, set error=1 (sticky until reset), pulse cpu_ack with cpu_rdata=16'hFFFF, and return to IDLE. The remaining byte of a word is skipped.
- Undefined: no counter; error tied 0; the block waits indefinitely for mem_ready.

Test Plan:
- Byte write addr 16'h0010, wdata 16'h00A5, then byte read addr 16'h0010 -> one mem_req burst each; second access has mem_we=0; cpu_rdata=16'h00A5 at ack; each cpu_ack exactly 1 cycle wide.
- Word write 16'h1234 at 16'h0020, then word read -> mem sees 8'h34 at 0020 and 8'h12 at 0021, each separated by >=1 low mem_req cycle; read returns 16'h1234.
- Word write 16'hBEEF at 16'hFFFF -> high byte goes to address 16'h0000; word read returns 16'hBEEF.
- Reset: rst_n low while in HI -> all outputs 0 immediately (async); after release, no cpu_ack and state IDLE; next request completes normally.
- Spurious mem_ready=1 held in IDLE for 5 cycles with cpu_req=0 -> mem_req, cpu_ack and cpu_busy stay 0.
- TRB_TIMEOUT_EN defined, mem_ready tied 0, byte read at 16'h0005 -> mem_req high for 15 cycles, then cpu_ack with cpu_rdata=16'hFFFF and error=1 staying high.

Source files
------------

// File: rtl/test_ram_bus_master.sv
// Byte/word CPU access sequencer for the block-RAM test memory.
// Optional mem_ready timeout watchdog: define TRB_TIMEOUT_EN.
module test_ram_bus_master #(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic                  cpu_wide,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [15:0]           cpu_wdata,
  output logic [15:0]           cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_ready,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_GAP,
    S_HI,
    S_ACK
  } state_t;

  state_t                state;
  logic                  we_q;
  logic                  wide_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           wdata_q;
  logic [7:0]            rlo_q;

`ifdef TRB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          in_xfer;
  logic          expired;

  assign in_xfer = (state == S_LO) || (state == S_HI);
  assign expired = in_xfer && !mem_ready &&
                   (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Cleared in the cycle before mem_req rises, so it restarts per byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      error <= 1'b0;
    end else begin
      if (!in_xfer)
        cnt <= '0;
      else if (!mem_ready)
        cnt <= cnt + 1'b1;
      if (expired)
        error <= 1'b1;
    end
  end
`else
  assign error = 1'b0 && (TIMEOUT_CYCLES >= 3);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      we_q      <= 1'b0;
      wide_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rlo_q     <= '0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_busy  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cpu_req) begin
            we_q      <= cpu_we;
            wide_q    <= cpu_wide;
            addr_q    <= cpu_addr;
            wdata_q   <= cpu_wdata;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata[7:0];
            mem_we    <= cpu_we;
            mem_req   <= 1'b1;
            cpu_busy  <= 1'b1;
            state     <= S_LO;
          end
        end
        S_LO, S_HI: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (state == S_LO) begin
              rlo_q <= mem_rdata;
              if (wide_q) begin
                state <= S_GAP;
              end else begin
                state   <= S_ACK;
                cpu_ack <= 1'b1;
                if (!we_q)
                  cpu_rdata <= {8'h00, mem_rdata};
              end
            end else begin
              state   <= S_ACK;
              cpu_ack <= 1'b1;
              if (!we_q)
                cpu_rdata <= {mem_rdata, rlo_q};
            end
          end
`ifdef TRB_TIMEOUT_EN
          else if (expired) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            cpu_ack   <= 1'b1;
            cpu_rdata <= 16'hFFFF;
            state     <= S_ACK;
          end
`endif
        end
        S_GAP: begin
          mem_addr  <= addr_q + 1'b1;
          mem_wdata <= wdata_q[15:8];
          mem_we    <= we_q;
          mem_req   <= 1'b1;
          state     <= S_HI;
        end
        S_ACK: begin
          cpu_busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_test_ram_bus_master.sv
// Self-checking bench for test_ram_bus_master with a randomized-latency
// RAM responder and a byte-array reference model of CPU-visible memory.
module tb_test_ram_bus_master;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req;
  logic          cpu_we;
  logic          cpu_wide;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_wdata;
  logic [15:0]   cpu_rdata;
  logic          cpu_ack;
  logic          cpu_busy;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = 8'h00;
  logic          mem_ready = 1'b0;
  logic          error;

  test_ram_bus_master #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_wide (cpu_wide),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ack  (cpu_ack),
    .cpu_busy (cpu_busy),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .error    (error)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]    ram     [0:65535];
  logic [7:0]    ref_mem [0:65535];
  logic [AW+8:0] log_q[$];
  logic [AW+8:0] snap = '0;
  logic [15:0]   exp_rdata = 16'h0000;
  logic          prev_req = 1'b0;
  int            cyc = 0;
  int            last_rdy = 0;
  int            stab_err = 0;
  int            wait_cnt = 0;
  bit            force_rdy = 1'b0;
  bit            hold = 1'b0;
  bit            hold_hi = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM responder: one-cycle ready pulse after a random 0..3 cycle wait
  always @(negedge clk) begin
    if (mem_req && prev_req && ({mem_we, mem_addr, mem_wdata} != snap))
      stab_err++;
    if (mem_req && !prev_req)
      snap = {mem_we, mem_addr, mem_wdata};
    prev_req = mem_req;
    if (force_rdy) begin
      mem_ready = 1'b1;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
    end else if (mem_req && !hold && !(hold_hi && log_q.size() > 0)) begin
      if (wait_cnt == 0) begin
        mem_ready = 1'b1;
        log_q.push_back({mem_we, mem_addr, mem_wdata});
        if (mem_we)
          ram[mem_addr] = mem_wdata;
        else
          mem_rdata = ram[mem_addr];
        last_rdy = cyc;
        wait_cnt = $urandom_range(0, 3);
      end else begin
        wait_cnt--;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic access(input bit we, input bit wide,
                        input logic [15:0] a, input logic [15:0] wd);
    logic [15:0]   a1;
    logic [AW+8:0] e;
    bit            got;
    int            nexp;
    a1 = a + 16'd1;
    nexp = wide ? 2 : 1;
    log_q.delete();
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_wide = wide;
    cpu_addr = a;
    cpu_wdata = wd;
    tick;
    chk("busy_on", {31'd0, cpu_busy}, 1);
    cpu_we = ~we;
    cpu_wide = ~wide;
    cpu_addr = 16'($urandom);
    cpu_wdata = 16'($urandom);
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (cpu_ack) begin
        got = 1'b1;
        break;
      end
      tick;
    end
    chk("ack_seen", {31'd0, got}, 1);
    chk("ack_latency", cyc - last_rdy, 1);
    if (we) begin
      ref_mem[a] = wd[7:0];
      if (wide) ref_mem[a1] = wd[15:8];
    end else begin
      exp_rdata = wide ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
    end
    chk("rdata", {16'd0, cpu_rdata}, {16'd0, exp_rdata});
    chk("error_low", {31'd0, error}, 0);
    chk("byte_count", log_q.size(), nexp);
    for (int i = 0; i < log_q.size() && i < nexp; i++) begin
      e = {we, (i == 0) ? a : a1, (i == 0) ? wd[7:0] : wd[15:8]};
      if (we)
        chk("mem_txn", {7'd0, log_q[i]}, {7'd0, e});
      else
        chk("mem_rd_txn", {15'd0, log_q[i][AW+8:8]}, {15'd0, e[AW+8:8]});
    end
    cpu_req = 1'b0;
    tick;
    chk("ack_pulse", {30'd0, cpu_ack, cpu_busy}, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {27'd0, cpu_ack, cpu_busy, mem_req, mem_we, error}, 0);
    chk({tag, "_rdata"}, {16'd0, cpu_rdata}, 0);
    chk({tag, "_addr"}, {16'd0, mem_addr}, 0);
    chk({tag, "_wdata"}, {24'd0, mem_wdata}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;
    int n;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    rst_n = 1'b0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_wide = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    repeat (3) tick;
    chk_zero("reset");
    rst_n = 1'b1;
    tick;

    access(1'b1, 1'b0, 16'h0010, 16'h00A5);
    access(1'b0, 1'b0, 16'h0010, 16'h0000);
    chk("byte_rd_A5", {16'd0, cpu_rdata}, 32'h00A5);
    access(1'b1, 1'b1, 16'h0020, 16'h1234);
    access(1'b0, 1'b1, 16'h0020, 16'h0000);
    chk("word_rd_1234", {16'd0, cpu_rdata}, 32'h1234);
    access(1'b1, 1'b1, 16'hFFFF, 16'hBEEF);
    chk("wrap_hi_byte", {24'd0, ram[16'h0000]}, 32'hBE);
    chk("wrap_lo_byte", {24'd0, ram[16'hFFFF]}, 32'hEF);
    access(1'b0, 1'b1, 16'hFFFF, 16'h0000);
    chk("wrap_rd_BEEF", {16'd0, cpu_rdata}, 32'hBEEF);

    force_rdy = 1'b1;
    repeat (5) begin
      tick;
      chk("spurious_ready", {29'd0, mem_req, cpu_ack, cpu_busy}, 0);
    end
    force_rdy = 1'b0;
    repeat (2) tick;

    hold_hi = 1'b1;
    log_q.delete();
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_wide = 1'b1;
    cpu_addr = 16'h0040;
    tick;
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (mem_req && mem_addr == 16'h0041) begin
        found = 1'b1;
        break;
      end
      tick;
    end
    chk("reach_hi", {31'd0, found}, 1);
    tick;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    cpu_req = 1'b0;
    hold_hi = 1'b0;
    exp_rdata = 16'h0000;
    tick;
    rst_n = 1'b1;
    repeat (4) begin
      tick;
      chk("post_rst_idle", {29'd0, cpu_ack, cpu_busy, mem_req}, 0);
    end
    access(1'b0, 1'b0, 16'h0020, 16'h0000);
    chk("post_rst_rd", {16'd0, cpu_rdata}, 32'h0034);

    repeat (30) begin
      logic [15:0] a;
      a = ($urandom_range(0, 7) == 0) ? 16'hFFFF
                                     : 16'h0100 + 16'($urandom_range(0, 15));
      access(1'($urandom), 1'($urandom), a, 16'($urandom));
    end
    chk("mem_stable", stab_err, 0);

`ifdef TRB_TIMEOUT_EN
    hold = 1'b1;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_wide = 1'b0;
    cpu_addr = 16'h0005;
    tick;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      if (!mem_req) break;
      n++;
      tick;
    end
    chk("to_req_cycles", n, 15);
    chk("to_ack", {31'd0, cpu_ack}, 1);
    chk("to_rdata", {16'd0, cpu_rdata}, 32'hFFFF);
    chk("to_error", {31'd0, error}, 1);
    cpu_req = 1'b0;
    repeat (3) begin
      tick;
      chk("to_sticky", {30'd0, error, cpu_ack}, 2);
    end
    hold = 1'b0;
`else
    n = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
